// File: rtl/sid_envelope_mux_pkg.sv
// Shared SID envelope types, rate/exponential tables and per-voice state layout.
package sid_envelope_mux_pkg;

  localparam int unsigned CYCLE_W = 5;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned ENV_W   = 8;
  localparam int unsigned RATE_W  = 15;
  localparam int unsigned EXP_W   = 5;
  localparam int unsigned SEL_W   = 3;

  typedef logic [CYCLE_W-1:0] cycle_t;

  // Voice v is serviced in cycle CYCLE_FIRST + v
  localparam cycle_t CYCLE_FIRST = CYCLE_W'(5);
  localparam cycle_t CYCLE_LAST  = CYCLE_W'(10);

  // Register image of one voice; 'rel' is the release nibble (release is a keyword)
  typedef struct packed {
    logic             gate;
    logic [NIB_W-1:0] attack;
    logic [NIB_W-1:0] decay;
    logic [NIB_W-1:0] sustain;
    logic [NIB_W-1:0] rel;
  } envelope_reg_t;

  typedef enum logic [1:0] {
    ST_ATTACK        = 2'd0,
    ST_DECAY_SUSTAIN = 2'd1,
    ST_RELEASE       = 2'd2
  } env_state_e;

  typedef struct packed {
    logic [ENV_W-1:0]  env;
    logic [RATE_W-1:0] rate_cnt;
    logic [EXP_W-1:0]  exp_cnt;
    env_state_e        state;
    logic              gate_prev;
  } voice_t;

  localparam voice_t VOICE_RESET = '{
    env:       '0,
    rate_cnt:  '0,
    exp_cnt:   '0,
    state:     ST_RELEASE,
    gate_prev: 1'b0
  };

  localparam logic [ENV_W-1:0] ENV_MAX = ENV_W'(255);

  // Lower bound of each exponential-divider band
  localparam logic [ENV_W-1:0] EXP_TH_1  = ENV_W'(94);
  localparam logic [ENV_W-1:0] EXP_TH_2  = ENV_W'(55);
  localparam logic [ENV_W-1:0] EXP_TH_4  = ENV_W'(27);
  localparam logic [ENV_W-1:0] EXP_TH_8  = ENV_W'(15);
  localparam logic [ENV_W-1:0] EXP_TH_16 = ENV_W'(7);
  localparam logic [ENV_W-1:0] EXP_TH_30 = ENV_W'(1);

  // Rate counter period for an ADSR nibble
  function automatic logic [RATE_W-1:0] rate_period(input logic [NIB_W-1:0] idx);
    rate_period = RATE_W'(31251);
    case (idx)
      4'd0:    rate_period = RATE_W'(8);
      4'd1:    rate_period = RATE_W'(31);
      4'd2:    rate_period = RATE_W'(62);
      4'd3:    rate_period = RATE_W'(94);
      4'd4:    rate_period = RATE_W'(148);
      4'd5:    rate_period = RATE_W'(219);
      4'd6:    rate_period = RATE_W'(266);
      4'd7:    rate_period = RATE_W'(312);
      4'd8:    rate_period = RATE_W'(391);
      4'd9:    rate_period = RATE_W'(976);
      4'd10:   rate_period = RATE_W'(1953);
      4'd11:   rate_period = RATE_W'(3125);
      4'd12:   rate_period = RATE_W'(3906);
      4'd13:   rate_period = RATE_W'(11719);
      4'd14:   rate_period = RATE_W'(19531);
      default: rate_period = RATE_W'(31251);
    endcase
  endfunction

  // Exponential divider period as a function of the current level
  function automatic logic [EXP_W-1:0] exp_period(input logic [ENV_W-1:0] lvl);
    exp_period = EXP_W'(1);
    if (lvl >= EXP_TH_1)       exp_period = EXP_W'(1);
    else if (lvl >= EXP_TH_2)  exp_period = EXP_W'(2);
    else if (lvl >= EXP_TH_4)  exp_period = EXP_W'(4);
    else if (lvl >= EXP_TH_8)  exp_period = EXP_W'(8);
    else if (lvl >= EXP_TH_16) exp_period = EXP_W'(16);
    else if (lvl >= EXP_TH_30) exp_period = EXP_W'(30);
    else                       exp_period = EXP_W'(1);
  endfunction

  // Sustain nibble replicated into a full 8-bit level
  function automatic logic [ENV_W-1:0] sustain_level(input logic [NIB_W-1:0] s);
    sustain_level = {s, s};
  endfunction

endpackage

// File: rtl/sid_envelope_mux.sv
// Six-voice time-multiplexed SID ADSR envelope generator.
module sid_envelope_mux
  import sid_envelope_mux_pkg::*;
(
  input  logic          clk,
  input  logic          res,
  input  cycle_t        cycle,
  input  envelope_reg_t ereg_5,
  output logic [7:0]    env
);

  voice_t v0_q, v1_q, v2_q, v3_q, v4_q, v5_q;

  logic               active_c;
  logic [SEL_W-1:0]   sel_c;
  voice_t             cur_c;
  voice_t             nxt_c;
  env_state_e         st_c;
  logic [NIB_W-1:0]   idx_c;
  logic [RATE_W-1:0]  period_c;
  logic               rate_tick_c;
  logic [EXP_W-1:0]   exp_inc_c;
  logic               exp_tick_c;

  // Decode which voice, if any, owns this cycle
  always_comb begin
    active_c = 1'b0;
    sel_c    = '0;
    if (cycle >= CYCLE_FIRST && cycle <= CYCLE_LAST) begin
      active_c = 1'b1;
      sel_c    = SEL_W'(cycle - CYCLE_FIRST);
    end
  end

  // Select the stored state of the active voice
  always_comb begin
    cur_c = v0_q;
    case (sel_c)
      3'd1:    cur_c = v1_q;
      3'd2:    cur_c = v2_q;
      3'd3:    cur_c = v3_q;
      3'd4:    cur_c = v4_q;
      3'd5:    cur_c = v5_q;
      default: cur_c = v0_q;
    endcase
  end

  // Gate edge, rate counter, exponential divider and level update for one voice
  always_comb begin
    nxt_c       = cur_c;
    st_c        = cur_c.state;
    idx_c       = ereg_5.rel;
    period_c    = '0;
    rate_tick_c = 1'b0;
    exp_inc_c   = '0;
    exp_tick_c  = 1'b0;

    // New state is applied before any tick of this update is processed
    if (ereg_5.gate && !cur_c.gate_prev) begin
      st_c = ST_ATTACK;
    end else if (!ereg_5.gate && cur_c.gate_prev) begin
      st_c = ST_RELEASE;
    end
    nxt_c.gate_prev = ereg_5.gate;
    nxt_c.state     = st_c;

    case (st_c)
      ST_ATTACK:        idx_c = ereg_5.attack;
      ST_DECAY_SUSTAIN: idx_c = ereg_5.decay;
      default:          idx_c = ereg_5.rel;
    endcase

    // Equality compare only: a period lowered below the count waits for the 15-bit wrap
    period_c       = rate_period(idx_c);
    rate_tick_c    = (cur_c.rate_cnt == period_c);
    nxt_c.rate_cnt = rate_tick_c ? '0 : cur_c.rate_cnt + RATE_W'(1);

    exp_inc_c = cur_c.exp_cnt + EXP_W'(1);
    if (rate_tick_c) begin
      if (st_c == ST_ATTACK) begin
        nxt_c.exp_cnt = '0;
        if (cur_c.env != ENV_MAX) begin
          nxt_c.env = cur_c.env + ENV_W'(1);
        end
        if (nxt_c.env == ENV_MAX) begin
          nxt_c.state = ST_DECAY_SUSTAIN;
        end
      end else begin
        exp_tick_c    = (exp_inc_c == exp_period(cur_c.env));
        nxt_c.exp_cnt = exp_tick_c ? '0 : exp_inc_c;
      end
    end

    // Decay stops at (or below) the sustain level; release freezes at zero
    if (exp_tick_c) begin
      if (st_c == ST_DECAY_SUSTAIN) begin
        if (cur_c.env > sustain_level(ereg_5.sustain)) begin
          nxt_c.env = cur_c.env - ENV_W'(1);
        end
      end else if (cur_c.env != '0) begin
        nxt_c.env = cur_c.env - ENV_W'(1);
      end
    end
  end

  // Per-voice state registers and the shared output level
  always_ff @(posedge clk) begin
    if (res) begin
      v0_q <= VOICE_RESET;
      v1_q <= VOICE_RESET;
      v2_q <= VOICE_RESET;
      v3_q <= VOICE_RESET;
      v4_q <= VOICE_RESET;
      v5_q <= VOICE_RESET;
      env  <= '0;
    end else if (active_c) begin
      case (sel_c)
        3'd0:    v0_q <= nxt_c;
        3'd1:    v1_q <= nxt_c;
        3'd2:    v2_q <= nxt_c;
        3'd3:    v3_q <= nxt_c;
        3'd4:    v4_q <= nxt_c;
        3'd5:    v5_q <= nxt_c;
        default: ;
      endcase
      env <= nxt_c.env;
    end
  end

endmodule

// File: tb/tb_sid_envelope_mux.sv
// Bench for sid_envelope_mux: vector table, directed ADSR sequences, random run vs reference model.
module tb_sid_envelope_mux;
  import sid_envelope_mux_pkg::*;

  logic          clk = 1'b0;
  logic          res;
  cycle_t        cycle;
  envelope_reg_t ereg;
  logic [7:0]    env;

  sid_envelope_mux dut (
    .clk    (clk),
    .res    (res),
    .cycle  (cycle),
    .ereg_5 (ereg),
    .env    (env)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: six voices held in plain integer arrays
  localparam int ATT = 0;
  localparam int DS  = 1;
  localparam int REL = 2;
  int rate_tbl [16] = '{8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31251};
  int m_env [6];
  int m_rc  [6];
  int m_ec  [6];
  int m_st  [6];
  bit m_pg  [6];
  int m_out;

  logic [7:0] slot_env [6];
  int first_at [256];
  logic [5:0] rg;

  typedef struct {
    int voice; bit gate; int attack; int decay; int sustain; int rel; int reps; int exp_env;
  } vec_t;
  vec_t tbl [13];

  function automatic int exp_div(input int e);
    if (e >= 94) return 1;
    if (e >= 55) return 2;
    if (e >= 27) return 4;
    if (e >= 15) return 8;
    if (e >= 7)  return 16;
    if (e >= 1)  return 30;
    return 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_env[i] = 0; m_rc[i] = 0; m_ec[i] = 0; m_st[i] = REL; m_pg[i] = 1'b0;
    end
    m_out = 0;
  endtask

  task automatic model_step(input int v, input envelope_reg_t e);
    int per;
    bit tick;
    if (e.gate && !m_pg[v]) m_st[v] = ATT;
    else if (!e.gate && m_pg[v]) m_st[v] = REL;
    m_pg[v] = e.gate;
    if (m_st[v] == ATT)     per = rate_tbl[int'(e.attack)];
    else if (m_st[v] == DS) per = rate_tbl[int'(e.decay)];
    else                    per = rate_tbl[int'(e.rel)];
    tick = (m_rc[v] == per);
    m_rc[v] = tick ? 0 : (m_rc[v] + 1) % 32768;
    if (tick) begin
      if (m_st[v] == ATT) begin
        m_ec[v] = 0;
        if (m_env[v] < 255) m_env[v] = m_env[v] + 1;
        if (m_env[v] == 255) m_st[v] = DS;
      end else begin
        m_ec[v] = (m_ec[v] + 1) % 32;
        if (m_ec[v] == exp_div(m_env[v])) begin
          m_ec[v] = 0;
          if (m_st[v] == DS) begin
            if (m_env[v] > int'(e.sustain) * 17) m_env[v] = m_env[v] - 1;
          end else if (m_env[v] > 0) begin
            m_env[v] = m_env[v] - 1;
          end
        end
      end
    end
    m_out = m_env[v];
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic envelope_reg_t mk(input bit g, input int a, input int d, input int s, input int r);
    envelope_reg_t x;
    x.gate = g; x.attack = 4'(a); x.decay = 4'(d); x.sustain = 4'(s); x.rel = 4'(r);
    return x;
  endfunction

  function automatic cycle_t idle_cycle();
    int k;
    k = $urandom_range(0, 25);
    return (k < 5) ? cycle_t'(k) : cycle_t'(k + 6);
  endfunction

  // One clock with the given inputs; model follows, outputs sampled 1 ns after the edge
  task automatic step(input cycle_t c, input envelope_reg_t e);
    cycle = c;
    ereg  = e;
    @(posedge clk);
    if (res) model_reset();
    else if (c >= 5 && c <= 10) model_step(int'(c) - 5, e);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step(idle_cycle(), envelope_reg_t'(17'($urandom)));
    res = 1'b0;
  endtask

  // One frame of cycles 0..11; res pulses in cycle rst_at (-1 for none)
  task automatic run_frame(input logic [5:0] gates, input int rst_at);
    envelope_reg_t e;
    for (int c = 0; c < 12; c++) begin
      if (c >= 5 && c <= 10) e = mk(gates[c-5], 0, 0, 0, 0);
      else                   e = envelope_reg_t'(17'($urandom));
      res = (c == rst_at);
      step(cycle_t'(c), e);
      res = 1'b0;
      if (c >= 5 && c <= 10) slot_env[c-5] = env;
      check($sformatf("frame_c%0d", c), 32'(env), m_out);
    end
  endtask

  initial begin
    envelope_reg_t e;
    int cyc;
    int prev;
    bit rose;

    res = 1'b1; cycle = '0; ereg = '0;
    model_reset();

    // Reset state, including a reset during a voice cycle with gate high
    step(cycle_t'(0), mk(0, 0, 0, 0, 0));
    step(cycle_t'(5), mk(1, 0, 0, 0, 0));
    check("reset_env", 32'(env), 0);
    res = 1'b0;

    // Table-driven short sequences across voices
    tbl[0]  = '{4, 1, 0, 0, 0, 0, 8,  0};
    tbl[1]  = '{4, 1, 0, 0, 0, 0, 1,  1};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 5,  0};
    tbl[3]  = '{4, 1, 0, 0, 0, 0, 9,  2};
    tbl[4]  = '{2, 0, 0, 0, 0, 0, 3,  0};
    tbl[5]  = '{4, 1, 0, 0, 0, 0, 18, 4};
    tbl[6]  = '{4, 0, 0, 0, 0, 0, 9,  4};
    tbl[7]  = '{4, 1, 1, 0, 0, 0, 31, 4};
    tbl[8]  = '{4, 1, 1, 0, 0, 0, 1,  5};
    tbl[9]  = '{5, 1, 0, 0, 0, 0, 9,  1};
    tbl[10] = '{4, 1, 1, 0, 0, 0, 1,  5};
    tbl[11] = '{3, 1, 2, 0, 0, 0, 62, 0};
    tbl[12] = '{3, 1, 2, 0, 0, 0, 1,  1};
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        step(cycle_t'(5 + tbl[i].voice),
             mk(tbl[i].gate, tbl[i].attack, tbl[i].decay, tbl[i].sustain, tbl[i].rel));
      check($sformatf("tbl%0d", i), 32'(env), tbl[i].exp_env);
      check($sformatf("tbl%0d_model", i), 32'(env), m_out);
      step(idle_cycle(), envelope_reg_t'(17'($urandom)));
      check($sformatf("tbl%0d_hold", i), 32'(env), tbl[i].exp_env);
    end

    // Only voice 4 gated: only its slot moves
    do_reset();
    for (int f = 0; f < 20; f++) run_frame(6'b010000, -1);
    for (int v = 0; v < 6; v++)
      check($sformatf("solo_slot%0d", v), 32'(slot_env[v]), (v == 4) ? 2 : 0);

    // Reset in the middle of attack on every voice
    for (int f = 0; f < 30; f++) run_frame(6'h3F, -1);
    check("pre_reset_slot0", 32'(slot_env[0]), 3);
    run_frame(6'h3F, 7);
    run_frame(6'h3F, -1);
    for (int v = 0; v < 6; v++)
      check($sformatf("post_reset_slot%0d", v), 32'(slot_env[v]), 0);

    // Voice 0: attack 0 to peak, decay 0 to sustain 0xA, then hold
    do_reset();
    e = mk(1, 0, 0, 10, 0);
    for (int n = 1; n <= 3360; n++) begin
      step(cycle_t'(5), e);
      if (n == 8)    check("att_n8", 32'(env), 0);
      if (n == 9)    check("att_n9", 32'(env), 1);
      if (n == 18)   check("att_n18", 32'(env), 2);
      if (n == 2294) check("att_n2294", 32'(env), 254);
      if (n == 2295) check("att_peak", 32'(env), 255);
      if (n == 2303) check("dec_n2303", 32'(env), 255);
      if (n == 2304) check("dec_first", 32'(env), 254);
      if (n == 3059) check("dec_n3059", 32'(env), 171);
      if (n == 3060) check("dec_sustain", 32'(env), 170);
      if (n == 3360) check("sustain_hold", 32'(env), 170);
    end
    check("adsr_model", 32'(env), m_out);

    // Release 0 from 0xAA down to zero
    for (int i = 0; i < 256; i++) first_at[i] = -1;
    first_at[170] = 0;
    prev = 170;
    rose = 1'b0;
    e = mk(0, 0, 0, 10, 0);
    for (int n = 1; n <= 6600; n++) begin
      step(cycle_t'(5), e);
      if (int'(env) > prev) rose = 1'b1;
      if (first_at[int'(env)] < 0) first_at[int'(env)] = n;
      prev = int'(env);
    end
    check("rel_gap_95_94", 32'(first_at[94] - first_at[95]), 9);
    check("rel_gap_94_93", 32'(first_at[93] - first_at[94]), 9);
    check("rel_gap_93_92", 32'(first_at[92] - first_at[93]), 18);
    check("rel_gap_54_53", 32'(first_at[53] - first_at[54]), 36);
    check("rel_gap_1_0", 32'(first_at[0] - first_at[1]), 270);
    check("rel_floor", 32'(env), 0);
    check("rel_no_rise", 32'(rose), 0);
    check("rel_model", 32'(env), m_out);

    // Voice 1: attack 15 leaves the counter at 1000, attack 0 must wait for the wrap
    do_reset();
    for (int n = 0; n < 1000; n++) step(cycle_t'(6), mk(1, 15, 0, 0, 0));
    check("slow_attack", 32'(env), 0);
    for (int n = 1; n <= 31777; n++) begin
      step(cycle_t'(6), mk(1, 0, 0, 0, 0));
      if (n == 9)     check("bug_no_early_tick", 32'(env), 0);
      if (n == 31776) check("bug_before_wrap_tick", 32'(env), 0);
    end
    check("bug_tick_after_wrap", 32'(env), 1);

    // Round-robin warm-up to the peaks, then random traffic with live nibble changes
    do_reset();
    for (int r = 0; r < 2300; r++)
      for (int v = 0; v < 6; v++) begin
        step(cycle_t'(5 + v), mk(1, 0, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3)));
        check("warm_env", 32'(env), m_out);
      end
    rg = 6'h3F;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 299) == 0) rg[$urandom_range(0, 5)] ^= 1'b1;
      if ($urandom_range(0, 3) != 0) cyc = 5 + $urandom_range(0, 5);
      else                           cyc = $urandom_range(0, 31);
      e = mk((cyc >= 5 && cyc <= 10) ? rg[cyc-5] : 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 15), $urandom_range(0, 2));
      res = ($urandom_range(0, 1999) == 0);
      step(cycle_t'(cyc), e);
      res = 1'b0;
      check("rand_env", 32'(env), m_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
